// File: rtl/branch_resolver.sv
`timescale 1ns/1ps
// branch_resolver: two-stage (IF/ID, ID/EX) tracking of predictor state with
// RISC-V control-flow decode and EX-stage branch resolution.
// Optional feature macro: BRANCH_STATS_EN (saturating retirement counters).
module branch_resolver (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        flush,
   input  logic [31:0] pc_1,
   input  logic        pred_taken_1,
   input  logic [31:0] pred_target_1,
   input  logic [31:0] instr_2,
   input  logic [31:0] rs1_3,
   input  logic [31:0] rs2_3,
   output logic [31:0] pc_3,
   output logic        is_branch_3,
   output logic        taken_3,
   output logic        prev_taken_3,
   output logic [31:0] target_3,
   output logic        mispredict_3,
   output logic [31:0] branch_cnt,
   output logic [31:0] mispred_cnt
);

   localparam logic [1:0] KIND_NONE = 2'd0;
   localparam logic [1:0] KIND_BR   = 2'd1;
   localparam logic [1:0] KIND_JAL  = 2'd2;
   localparam logic [1:0] KIND_JALR = 2'd3;

   localparam logic [6:0] OP_BR   = 7'b1100011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;
   localparam logic [6:0] OP_JALR = 7'b1100111;

   // Branch condition evaluation; 010/011 are not valid conditions and resolve not-taken
   function automatic logic br_cmp(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      logic signed [31:0] sa;
      logic signed [31:0] sb;
      logic               res;
      sa = a;
      sb = b;
      case (f3)
         3'b000:  res = (a == b);
         3'b001:  res = (a != b);
         3'b100:  res = (sa < sb);
         3'b101:  res = (sa >= sb);
         3'b110:  res = (a < b);
         3'b111:  res = (a >= b);
         default: res = 1'b0;
      endcase
      return res;
   endfunction

   // IF/ID register
   logic        r_vld_p0;
   logic [31:0] r_pc_p0;
   logic        r_pt_p0;
   logic [31:0] r_ptgt_p0;

   // ID/EX register
   logic        r_vld_p1;
   logic [31:0] r_pc_p1;
   logic        r_pt_p1;
   logic [31:0] r_ptgt_p1;
   logic [1:0]  r_kind_p1;
   logic [2:0]  r_f3_p1;
   logic [31:0] r_imm_p1;

   logic [1:0]  w_kind;
   logic [31:0] w_imm;
   logic [6:0]  w_opcode;

   assign w_opcode = instr_2[6:0];

   // Decode control-flow kind and its sign-extended immediate from the ID instruction
   always_comb begin
      w_kind = KIND_NONE;
      w_imm  = 32'd0;
      case (w_opcode)
         OP_BR: begin
            w_kind = KIND_BR;
            w_imm  = {{20{instr_2[31]}}, instr_2[7], instr_2[30:25], instr_2[11:8], 1'b0};
         end
         OP_JAL: begin
            w_kind = KIND_JAL;
            w_imm  = {{12{instr_2[31]}}, instr_2[19:12], instr_2[20], instr_2[30:21], 1'b0};
         end
         OP_JALR: begin
            w_kind = KIND_JALR;
            w_imm  = {{20{instr_2[31]}}, instr_2[31:20]};
         end
         default: begin
            w_kind = KIND_NONE;
            w_imm  = 32'd0;
         end
      endcase
   end

   // Pipeline advance: reset clears everything, stall freezes, flush kills both entries
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_vld_p0  <= 1'b0;
         r_pc_p0   <= 32'd0;
         r_pt_p0   <= 1'b0;
         r_ptgt_p0 <= 32'd0;
         r_vld_p1  <= 1'b0;
         r_pc_p1   <= 32'd0;
         r_pt_p1   <= 1'b0;
         r_ptgt_p1 <= 32'd0;
         r_kind_p1 <= KIND_NONE;
         r_f3_p1   <= 3'd0;
         r_imm_p1  <= 32'd0;
      end else if (!stall) begin
         // IF -> IF/ID
         r_vld_p0  <= ~flush;
         r_pc_p0   <= pc_1;
         r_pt_p0   <= pred_taken_1;
         r_ptgt_p0 <= pred_target_1;
         // IF/ID -> ID/EX
         r_vld_p1  <= r_vld_p0 & ~flush;
         r_pc_p1   <= r_pc_p0;
         r_pt_p1   <= r_pt_p0;
         r_ptgt_p1 <= r_ptgt_p0;
         r_kind_p1 <= w_kind;
         r_f3_p1   <= instr_2[14:12];
         r_imm_p1  <= w_imm;
      end
   end

   // EX stage resolution (combinational from ID/EX and forwarded operands)
   logic        w_ctl;
   logic        w_taken;
   logic [31:0] w_seq_pc;
   logic [31:0] w_rel_tgt;
   logic [31:0] w_jalr_sum;
   logic [31:0] w_jalr_tgt;
   logic [31:0] w_target;

   assign w_ctl      = r_vld_p1 & (r_kind_p1 != KIND_NONE);
   assign w_seq_pc   = r_pc_p1 + 32'd4;
   assign w_rel_tgt  = r_pc_p1 + r_imm_p1;
   assign w_jalr_sum = rs1_3 + r_imm_p1;
   assign w_jalr_tgt = {w_jalr_sum[31:1], 1'b0};

   // Actual direction: compare result for BR, always taken for jumps
   always_comb begin
      w_taken = 1'b0;
      if (w_ctl) begin
         case (r_kind_p1)
            KIND_BR:   w_taken = br_cmp(r_f3_p1, rs1_3, rs2_3);
            KIND_JAL:  w_taken = 1'b1;
            KIND_JALR: w_taken = 1'b1;
            default:   w_taken = 1'b0;
         endcase
      end
   end

   // Actual next PC: fall-through unless taken
   always_comb begin
      w_target = w_seq_pc;
      if (w_taken) begin
         w_target = (r_kind_p1 == KIND_JALR) ? w_jalr_tgt : w_rel_tgt;
      end
   end

   assign pc_3         = r_pc_p1;
   assign is_branch_3  = w_ctl;
   assign taken_3      = w_taken;
   assign prev_taken_3 = r_pt_p1;
   assign target_3     = w_target;
   assign mispredict_3 = w_ctl & ((w_taken != r_pt_p1) |
                                  (w_taken & r_pt_p1 & (w_target != r_ptgt_p1)));

`ifdef BRANCH_STATS_EN
   // Counters stick at all-ones instead of wrapping
   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   logic [31:0] r_branch_cnt;
   logic [31:0] r_mispred_cnt;

   // Count each EX control-flow instruction once, on the edge it leaves EX
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_branch_cnt  <= 32'd0;
         r_mispred_cnt <= 32'd0;
      end else if (!stall && w_ctl) begin
         r_branch_cnt <= sat_inc(r_branch_cnt);
         if (mispredict_3) begin
            r_mispred_cnt <= sat_inc(r_mispred_cnt);
         end
      end
   end

   assign branch_cnt  = r_branch_cnt;
   assign mispred_cnt = r_mispred_cnt;
`else
   assign branch_cnt  = 32'd0;
   assign mispred_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_branch_resolver.sv
`timescale 1ns/1ps
// Directed bench for branch_resolver: decode, resolution, flush, stall, reset.
module tb_branch_resolver;

   logic        clk;
   logic        rst_n;
   logic        stall;
   logic        flush;
   logic [31:0] pc_1;
   logic        pred_taken_1;
   logic [31:0] pred_target_1;
   logic [31:0] instr_2;
   logic [31:0] rs1_3;
   logic [31:0] rs2_3;
   logic [31:0] pc_3;
   logic        is_branch_3;
   logic        taken_3;
   logic        prev_taken_3;
   logic [31:0] target_3;
   logic        mispredict_3;
   logic [31:0] branch_cnt;
   logic [31:0] mispred_cnt;

   int errors = 0;
   int checks = 0;

   localparam logic [31:0] NOP = 32'h0000_0013;

   branch_resolver dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .stall         (stall),
      .flush         (flush),
      .pc_1          (pc_1),
      .pred_taken_1  (pred_taken_1),
      .pred_target_1 (pred_target_1),
      .instr_2       (instr_2),
      .rs1_3         (rs1_3),
      .rs2_3         (rs2_3),
      .pc_3          (pc_3),
      .is_branch_3   (is_branch_3),
      .taken_3       (taken_3),
      .prev_taken_3  (prev_taken_3),
      .target_3      (target_3),
      .mispredict_3  (mispredict_3),
      .branch_cnt    (branch_cnt),
      .mispred_cnt   (mispred_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_cnt(input string tag, input logic [31:0] br, input logic [31:0] mp);
`ifdef BRANCH_STATS_EN
      chk({tag, "_brcnt"}, branch_cnt, br);
      chk({tag, "_mpcnt"}, mispred_cnt, mp);
`else
      chk({tag, "_brcnt"}, branch_cnt, 32'd0);
      chk({tag, "_mpcnt"}, mispred_cnt, 32'd0);
      if (br == 32'hFFFF_FFFF || mp == 32'hFFFF_FFFF) $display("note: counters disabled");
`endif
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [2:0] f3);
      return {imm[12], imm[10:5], 5'd2, 5'd1, f3, imm[4:1], imm[11], 7'b1100011};
   endfunction

   function automatic logic [31:0] enc_j(input logic [31:0] imm);
      return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd1, 7'b1101111};
   endfunction

   function automatic logic [31:0] enc_jalr(input logic [31:0] imm);
      return {imm[11:0], 5'd1, 3'b000, 5'd1, 7'b1100111};
   endfunction

   // Fetch one instruction, decode it on the next edge; it sits in EX afterwards
   task automatic issue(input logic [31:0] pc, input logic pt, input logic [31:0] ptgt,
                        input logic [31:0] instr);
      pc_1 = pc; pred_taken_1 = pt; pred_target_1 = ptgt; instr_2 = NOP;
      tick();
      pc_1 = 32'd0; pred_taken_1 = 1'b0; pred_target_1 = 32'd0; instr_2 = instr;
      tick();
      instr_2 = NOP;
   endtask

   task automatic chk_ex(input string tag, input logic [31:0] pc, input logic br,
                         input logic tk, input logic [31:0] tgt, input logic mp);
      chk({tag, "_pc"},     pc_3,         pc);
      chk({tag, "_isbr"},   is_branch_3,  {31'd0, br});
      chk({tag, "_taken"},  taken_3,      {31'd0, tk});
      chk({tag, "_target"}, target_3,     tgt);
      chk({tag, "_mispr"},  mispredict_3, {31'd0, mp});
   endtask

   initial begin
      rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
      pc_1 = 32'd0; pred_taken_1 = 1'b0; pred_target_1 = 32'd0;
      instr_2 = NOP; rs1_3 = 32'd0; rs2_3 = 32'd0;
      tick();
      tick();

      // Reset state
      chk_ex("reset", 32'd0, 1'b0, 1'b0, 32'd4, 1'b0);
      chk("reset_prev", prev_taken_3, 32'd0);
      chk_cnt("reset", 32'd0, 32'd0);
      rst_n = 1'b1;

      // BEQ pc 0x40 imm +0x20, equal operands, predicted not-taken
      issue(32'h40, 1'b0, 32'h44, enc_b(32'h20, 3'b000));
      rs1_3 = 32'd5; rs2_3 = 32'd5; #1;
      chk_ex("beq", 32'h40, 1'b1, 1'b1, 32'h60, 1'b1);
      chk("beq_prev", prev_taken_3, 32'd0);

      // BLT signed: -1 < 1, predicted taken to correct target
      issue(32'h100, 1'b1, 32'h110, enc_b(32'h10, 3'b100));
      rs1_3 = 32'hFFFF_FFFF; rs2_3 = 32'd1; #1;
      chk_ex("blt", 32'h100, 1'b1, 1'b1, 32'h110, 1'b0);
      chk("blt_prev", prev_taken_3, 32'd1);

      // BLTU same operands: 0xFFFFFFFF is not below 1
      issue(32'h200, 1'b1, 32'h210, enc_b(32'h10, 3'b110));
      rs1_3 = 32'hFFFF_FFFF; rs2_3 = 32'd1; #1;
      chk_ex("bltu", 32'h200, 1'b1, 1'b0, 32'h204, 1'b1);

      // JALR rs1=0x103 imm 0: target 0x102 vs predicted 0x100
      issue(32'h300, 1'b1, 32'h100, enc_jalr(32'h0));
      rs1_3 = 32'h103; rs2_3 = 32'd0; #1;
      chk_ex("jalr", 32'h300, 1'b1, 1'b1, 32'h102, 1'b1);

      // JAL backwards by 8, predicted correctly
      issue(32'h400, 1'b1, 32'h3F8, enc_j(32'hFFFF_FFF8));
      #1;
      chk_ex("jal", 32'h400, 1'b1, 1'b1, 32'h3F8, 1'b0);

      // Reserved branch condition 010: not taken, still a branch
      issue(32'h500, 1'b0, 32'h0, enc_b(32'h8, 3'b010));
      rs1_3 = 32'd7; rs2_3 = 32'd7; #1;
      chk_ex("br010", 32'h500, 1'b1, 1'b0, 32'h504, 1'b0);

      // BGE signed with target wrapping past 2^32
      issue(32'hFFFF_FFF0, 1'b1, 32'h10, enc_b(32'h20, 3'b101));
      rs1_3 = 32'd1; rs2_3 = 32'hFFFF_FFFF; #1;
      chk_ex("bge_wrap", 32'hFFFF_FFF0, 1'b1, 1'b1, 32'h10, 1'b0);

      // Non-control instruction
      issue(32'h600, 1'b1, 32'h0, 32'h0050_0093);
      #1;
      chk_ex("none", 32'h600, 1'b0, 1'b0, 32'h604, 1'b0);
      chk_cnt("after_seq", 32'd7, 32'd3);

      // Flush with branches in IF/ID and ID/EX
      rs1_3 = 32'd5; rs2_3 = 32'd5;
      pc_1 = 32'h700; pred_taken_1 = 1'b0; pred_target_1 = 32'd0; instr_2 = NOP;
      tick();
      pc_1 = 32'h704; instr_2 = enc_b(32'h20, 3'b000);
      tick();
      chk("flush_pre_isbr", is_branch_3, 32'd1);
      flush = 1'b1; pc_1 = 32'h708; instr_2 = enc_b(32'h20, 3'b000);
      tick();
      chk("flush_ex1_isbr", is_branch_3, 32'd0);
      flush = 1'b0; pc_1 = 32'h70C; instr_2 = enc_b(32'h20, 3'b000);
      tick();
      chk("flush_ex2_isbr", is_branch_3, 32'd0);
      pc_1 = 32'h710; instr_2 = enc_b(32'h20, 3'b000);
      tick();
      chk("flush_resume_isbr", is_branch_3, 32'd1);
      chk("flush_resume_pc", pc_3, 32'h70C);
      chk_cnt("after_flush", 32'd8, 32'd4);

      // Stall with mispredicting BNE in EX and flush pending
      issue(32'h800, 1'b0, 32'h0, enc_b(32'h40, 3'b001));
      rs1_3 = 32'd1; rs2_3 = 32'd2; #1;
      chk_cnt("pre_stall", 32'd9, 32'd5);
      stall = 1'b1; flush = 1'b1;
      for (int i = 0; i < 3; i++) begin
         pc_1 = 32'hA00 + 32'(i * 4); instr_2 = enc_j(32'h10);
         tick();
         chk_ex("stall_hold", 32'h800, 1'b1, 1'b1, 32'h840, 1'b1);
         chk_cnt("stall_hold", 32'd9, 32'd5);
      end
      stall = 1'b0;
      tick();
      chk("release_ex1_isbr", is_branch_3, 32'd0);
      chk_cnt("release", 32'd10, 32'd6);
      flush = 1'b0; instr_2 = enc_j(32'h10);
      tick();
      chk("release_ex2_isbr", is_branch_3, 32'd0);
      chk_cnt("release2", 32'd10, 32'd6);

      // Reset during a stall with valid entries
      issue(32'h900, 1'b1, 32'h0, enc_j(32'h10));
      #1;
      chk("pre_rst_isbr", is_branch_3, 32'd1);
      pc_1 = 32'hB00; pred_taken_1 = 1'b1; instr_2 = enc_j(32'h10);
      stall = 1'b1; rst_n = 1'b0;
      tick();
      chk_ex("stall_rst", 32'd0, 1'b0, 1'b0, 32'd4, 1'b0);
      chk("stall_rst_prev", prev_taken_3, 32'd0);
      chk_cnt("stall_rst", 32'd0, 32'd0);
      rst_n = 1'b1; stall = 1'b0; instr_2 = enc_j(32'h10);
      tick();
      chk("post_rst_isbr", is_branch_3, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
